dbg_cmd_sequencer: RTL and testbench

//  Host-debug command sequencer between the UART byte link and the simproc core/memory.
//  - Assembles 3-byte frames {cmd, addr, data} from the UART receiver.
//  - Executes each frame against the core and memory:

---
 rtl/dbg_cmd_sequencer_if.sv | 33 +++
 rtl/dbg_cmd_sequencer.sv | 163 ++++++++++++++++
 tb/tb_dbg_cmd_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_cmd_sequencer_if.sv
// Byte-link, memory-port and core-control signals between the debug sequencer and its surroundings.
// The slave modport is the sequencer's view; master is the environment (UART, memory, core).
interface dbg_cmd_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_done;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       run;
    logic       step_pulse;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic [7:0] pc_val;
    logic       busy;
    logic       err_ovr;

    modport slave (
        input  rx_data, rx_valid, tx_done, mem_rdata, pc_val,
        output tx_data, tx_en, mem_addr, mem_wdata, mem_we, mem_re,
               run, step_pulse, pc_load, pc_load_val, busy, err_ovr
    );

    modport master (
        output rx_data, rx_valid, tx_done, mem_rdata, pc_val,
        input  tx_data, tx_en, mem_addr, mem_wdata, mem_we, mem_re,
               run, step_pulse, pc_load, pc_load_val, busy, err_ovr
    );
endinterface

// File: rtl/dbg_cmd_sequencer.sv
// Host-debug sequencer: assembles {cmd,addr,data} frames, executes them, answers with one byte.
// Latency: strobes one cycle after the 3rd byte, tx_en one cycle later (two for READ); bytes arriving mid-execution are dropped.
module dbg_cmd_sequencer #(
    parameter int TO_BITS = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [TO_BITS-1:0] i_timeout_cyc,
    dbg_cmd_sequencer_if.slave bus
);
    localparam logic [7:0] CMD_PING   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_RUN    = 8'h04;
    localparam logic [7:0] CMD_HALT   = 8'h05;
    localparam logic [7:0] CMD_STEP   = 8'h06;
    localparam logic [7:0] CMD_SET_PC = 8'h07;
    localparam logic [7:0] CMD_GET_PC = 8'h08;
    localparam logic [7:0] PING_RESP  = 8'hA5;
    localparam logic [7:0] ACK        = 8'h4B;
    localparam logic [7:0] NAK        = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_B1, S_B2, S_EXEC, S_MRD, S_SEND, S_WAIT_TX
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_cmd, r_addr, r_data, r_resp;
    logic [7:0]         w_cmd_nxt, w_addr_nxt, w_data_nxt, w_resp_nxt;
    logic [TO_BITS-1:0] r_cnt, w_cnt_nxt;
    logic               r_run, w_run_nxt;
    logic               r_err_ovr, w_err_ovr_nxt;
    logic               w_mem_we, w_mem_re, w_step, w_pc_load, w_tx_en;
    logic               w_to_hit, w_not_accepting;

    assign w_to_hit        = (i_timeout_cyc != '0) && (r_cnt == i_timeout_cyc);
    assign w_not_accepting = (r_state == S_EXEC) || (r_state == S_MRD) ||
                             (r_state == S_SEND) || (r_state == S_WAIT_TX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_resp    <= '0;
            r_cnt     <= '0;
            r_run     <= 1'b0;
            r_err_ovr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd     <= w_cmd_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_resp    <= w_resp_nxt;
            r_cnt     <= w_cnt_nxt;
            r_run     <= w_run_nxt;
            r_err_ovr <= w_err_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_nxt     = r_cmd;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_resp_nxt    = r_resp;
        w_cnt_nxt     = r_cnt;
        w_run_nxt     = r_run;
        w_err_ovr_nxt = r_err_ovr | (bus.rx_valid & w_not_accepting);
        w_mem_we      = 1'b0;
        w_mem_re      = 1'b0;
        w_step        = 1'b0;
        w_pc_load     = 1'b0;
        w_tx_en       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    w_cmd_nxt   = bus.rx_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_B1;
                end
            end
            S_B1, S_B2: begin
                // A byte landing on the timeout cycle still counts.
                if (bus.rx_valid) begin
                    if (r_state == S_B1) begin
                        w_addr_nxt  = bus.rx_data;
                        w_state_nxt = S_B2;
                    end else begin
                        w_data_nxt  = bus.rx_data;
                        w_state_nxt = S_EXEC;
                    end
                    w_cnt_nxt = '0;
                end else if (w_to_hit) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + TO_BITS'(1);
                end
            end
            S_EXEC: begin
                w_state_nxt = S_SEND;
                w_resp_nxt  = NAK;
                case (r_cmd)
                    CMD_PING:  w_resp_nxt = PING_RESP;
                    CMD_WRITE: if (!r_run) begin
                        w_mem_we   = 1'b1;
                        w_resp_nxt = ACK;
                    end
                    CMD_READ: if (!r_run) begin
                        w_mem_re    = 1'b1;
                        w_state_nxt = S_MRD;
                    end
                    CMD_RUN: begin
                        w_run_nxt  = 1'b1;
                        w_resp_nxt = ACK;
                    end
                    CMD_HALT: begin
                        w_run_nxt  = 1'b0;
                        w_resp_nxt = ACK;
                    end
                    CMD_STEP: if (!r_run) begin
                        w_step     = 1'b1;
                        w_resp_nxt = ACK;
                    end
                    CMD_SET_PC: if (!r_run) begin
                        w_pc_load  = 1'b1;
                        w_resp_nxt = ACK;
                    end
                    CMD_GET_PC: w_resp_nxt = bus.pc_val;
                    default:    w_resp_nxt = NAK;
                endcase
            end
            S_MRD: begin
                w_resp_nxt  = bus.mem_rdata;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_tx_en     = 1'b1;
                w_state_nxt = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (bus.tx_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.tx_data     = r_resp;
    assign bus.tx_en       = w_tx_en;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wdata   = r_data;
    assign bus.mem_we      = w_mem_we;
    assign bus.mem_re      = w_mem_re;
    assign bus.run         = r_run;
    assign bus.step_pulse  = w_step;
    assign bus.pc_load     = w_pc_load;
    assign bus.pc_load_val = r_addr;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.err_ovr     = r_err_ovr;
endmodule

// File: tb/tb_dbg_cmd_sequencer.sv
// Directed bench for dbg_cmd_sequencer with a registered memory and a fixed-delay transmitter model.
module tb_dbg_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] timeout_cyc;
    int          n_checks = 0;
    int          n_err    = 0;

    dbg_cmd_sequencer_if ifc();

    dbg_cmd_sequencer #(.TO_BITS(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_timeout_cyc (timeout_cyc),
        .bus           (ifc)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_wdata;
        if (ifc.mem_re) ifc.mem_rdata <= mem[ifc.mem_addr];
    end

    // Transmitter finishes three negedges after it sees tx_en.
    initial begin
        ifc.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            ifc.tx_done = 1'b0;
            if (ifc.tx_en) begin
                repeat (3) @(negedge clk);
                ifc.tx_done = 1'b1;
            end
        end
    end

    int   n_tx = 0, n_we = 0, n_re = 0, n_step = 0, n_pcl = 0;
    logic long_strobe = 1'b0;
    logic p_tx = 1'b0, p_we = 1'b0, p_re = 1'b0, p_st = 1'b0, p_pl = 1'b0;
    always @(negedge clk) begin
        if (ifc.tx_en)      n_tx++;
        if (ifc.mem_we)     n_we++;
        if (ifc.mem_re)     n_re++;
        if (ifc.step_pulse) n_step++;
        if (ifc.pc_load)    n_pcl++;
        if ((p_tx && ifc.tx_en) || (p_we && ifc.mem_we) || (p_re && ifc.mem_re) ||
            (p_st && ifc.step_pulse) || (p_pl && ifc.pc_load))
            long_strobe = 1'b1;
        p_tx = ifc.tx_en; p_we = ifc.mem_we; p_re = ifc.mem_re;
        p_st = ifc.step_pulse; p_pl = ifc.pc_load;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        @(negedge clk);
        ifc.rx_valid = 1'b0;
    endtask

    // Snapshot of the EXEC cycle (one cycle after the 3rd byte).
    logic       e_we, e_re, e_step, e_pcl;
    logic [7:0] e_addr, e_wdata, e_pclv;

    task automatic do_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] resp, output int lat);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        e_we = ifc.mem_we; e_re = ifc.mem_re; e_step = ifc.step_pulse; e_pcl = ifc.pc_load;
        e_addr = ifc.mem_addr; e_wdata = ifc.mem_wdata; e_pclv = ifc.pc_load_val;
        lat  = -1;
        resp = 8'h00;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            if (ifc.tx_en) begin
                lat  = i;
                resp = ifc.tx_data;
            end else begin
                @(negedge clk);
            end
        end
        for (int i = 0; i < 20 && ifc.busy; i++) @(negedge clk);
        chk("frame_idle", ifc.busy, 1'b0);
    endtask

    logic [7:0] r;
    int         lat;
    int         s_tx, s_we, s_step, s_pcl;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1;
        timeout_cyc = 16'd0;
        ifc.rx_data = 8'h00; ifc.rx_valid = 1'b0; ifc.pc_val = 8'h5C;
        repeat (3) @(negedge clk);
        chk("rst_busy", ifc.busy, 1'b0);
        chk("rst_run", ifc.run, 1'b0);
        chk("rst_tx_en", ifc.tx_en, 1'b0);
        chk("rst_tx_data", ifc.tx_data, 8'h00);
        chk("rst_err_ovr", ifc.err_ovr, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Ping
        s_tx = n_tx;
        do_frame(8'h01, 8'h00, 8'h00, r, lat);
        chk("ping_resp", r, 8'hA5);
        chk("ping_lat", lat, 1);
        chk("ping_tx_once", n_tx - s_tx, 1);

        // Write then read while halted
        do_frame(8'h02, 8'h10, 8'h05, r, lat);
        chk("wr_we", e_we, 1'b1);
        chk("wr_addr", e_addr, 8'h10);
        chk("wr_wdata", e_wdata, 8'h05);
        chk("wr_resp", r, 8'h4B);
        chk("wr_lat", lat, 1);
        chk("wr_mem", mem[8'h10], 8'h05);
        do_frame(8'h03, 8'h10, 8'h00, r, lat);
        chk("rd_re", e_re, 1'b1);
        chk("rd_lat", lat, 2);
        chk("rd_resp", r, 8'h05);

        // Core running: control and memory refused, GET_PC allowed
        do_frame(8'h04, 8'h00, 8'h00, r, lat);
        chk("run_resp", r, 8'h4B);
        chk("run_level", ifc.run, 1'b1);
        do_frame(8'h04, 8'h00, 8'h00, r, lat);
        chk("run_again_resp", r, 8'h4B);
        s_we = n_we; s_step = n_step; s_pcl = n_pcl;
        do_frame(8'h06, 8'h00, 8'h00, r, lat);
        chk("run_step_nak", r, 8'h3F);
        do_frame(8'h07, 8'h79, 8'h00, r, lat);
        chk("run_setpc_nak", r, 8'h3F);
        do_frame(8'h02, 8'h20, 8'h77, r, lat);
        chk("run_wr_nak", r, 8'h3F);
        chk("run_no_step", n_step - s_step, 0);
        chk("run_no_pcl", n_pcl - s_pcl, 0);
        chk("run_no_we", n_we - s_we, 0);
        chk("run_mem_intact", mem[8'h20], 8'h00);
        do_frame(8'h08, 8'h00, 8'h00, r, lat);
        chk("getpc_resp", r, 8'h5C);
        do_frame(8'h05, 8'h00, 8'h00, r, lat);
        chk("halt_resp", r, 8'h4B);
        chk("halt_level", ifc.run, 1'b0);

        // Halted control
        s_step = n_step;
        do_frame(8'h07, 8'h79, 8'h00, r, lat);
        chk("setpc_pulse", e_pcl, 1'b1);
        chk("setpc_val", e_pclv, 8'h79);
        chk("setpc_resp", r, 8'h4B);
        do_frame(8'h06, 8'h00, 8'h00, r, lat);
        chk("step_pulse", e_step, 1'b1);
        chk("step_count", n_step - s_step, 1);
        chk("step_resp", r, 8'h4B);
        do_frame(8'hFF, 8'h00, 8'h00, r, lat);
        chk("bad_op_nak", r, 8'h3F);

        // Inter-byte timeout
        timeout_cyc = 16'd50;
        s_tx = n_tx;
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (40) @(negedge clk);
        chk("to_still_busy", ifc.busy, 1'b1);
        repeat (20) @(negedge clk);
        chk("to_idle", ifc.busy, 1'b0);
        chk("to_no_tx", n_tx - s_tx, 0);
        do_frame(8'h01, 8'h00, 8'h00, r, lat);
        chk("to_ping_resp", r, 8'hA5);

        // Overrun during WAIT_TX
        s_tx = n_tx;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        chk("ovr_tx_en", ifc.tx_en, 1'b1);
        @(negedge clk);
        send_byte(8'h02);
        for (int i = 0; i < 20 && ifc.busy; i++) @(negedge clk);
        chk("ovr_flag", ifc.err_ovr, 1'b1);
        chk("ovr_idle", ifc.busy, 1'b0);
        chk("ovr_one_tx", n_tx - s_tx, 1);
        do_frame(8'h01, 8'h00, 8'h00, r, lat);
        chk("ovr_ping_resp", r, 8'hA5);
        chk("ovr_sticky", ifc.err_ovr, 1'b1);

        // Reset mid-frame while running
        do_frame(8'h04, 8'h00, 8'h00, r, lat);
        chk("pre_rst_run", ifc.run, 1'b1);
        s_tx = n_tx;
        send_byte(8'h03);
        send_byte(8'h10);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", ifc.busy, 1'b0);
        chk("mid_rst_run", ifc.run, 1'b0);
        chk("mid_rst_err", ifc.err_ovr, 1'b0);
        chk("mid_rst_addr", ifc.mem_addr, 8'h00);
        chk("mid_rst_txdata", ifc.tx_data, 8'h00);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_tx", n_tx - s_tx, 0);
        do_frame(8'h01, 8'h00, 8'h00, r, lat);
        chk("post_rst_ping", r, 8'hA5);
        do_frame(8'h03, 8'h10, 8'h00, r, lat);
        chk("post_rst_read", r, 8'h05);

        chk("strobe_width", long_strobe, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
